// File: rtl/cpu_hs_if.sv
// Memory port, input/output channels and status of the cpu_hs core.
// master = core side, slave = memory/board side.
interface cpu_hs_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] mem_in;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] sp;
    logic                  halted;

    modport master (
        input  mem_in, in_data, in_valid, out_ready,
        output mem_we, mem_addr, mem_data, in_ready, out_data, out_valid, pc, sp, halted
    );
    modport slave (
        output mem_in, in_data, in_valid, out_ready,
        input  mem_we, mem_addr, mem_data, in_ready, out_data, out_valid, pc, sp, halted
    );
endinterface

// File: rtl/cpu_hs.sv
// Multicycle memory-to-memory CPU: 6-8 cycles per direct instruction, +2 per indirect field.
// Stalls in IN_WAIT until in_valid, in OUT_WAIT until out_ready; HALT holds until reset.
module cpu_hs #(
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] PC_START   = ADDR_WIDTH'(8),
    parameter logic [ADDR_WIDTH-1:0] SP_START   = {ADDR_WIDTH{1'b1}}
) (
    input  logic     clk,
    input  logic     rst_n,
    cpu_hs_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH_A, S_FETCH_D, S_DECODE, S_SRC_A, S_SRC_D, S_SRC_IA, S_SRC_ID,
        S_DST_A, S_DST_D, S_WRITE, S_IN_WAIT, S_OUT_WAIT, S_HALT
    } state_e;

    localparam logic [3:0] OP_MOV = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_MUL = 4'h3,
                           OP_DIV = 4'h4, OP_IN = 4'h7, OP_OUT = 4'h8, OP_STOP = 4'hF;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, ptr_q, ptr_d, dst_q, dst_d;
    logic [15:0]           ir_q, ir_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d, opn_q, opn_d;

    logic [3:0]            op, f1, cur_fld;
    logic                  is_alu, src_done;
    logic [DATA_WIDTH-1:0] alu_res;

    assign op     = ir_q[15:12];
    assign f1     = ir_q[11:8];
    assign is_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
    // OUT reads its operand through f1; other instructions read f2 then f3.
    assign cur_fld = (op == OP_OUT) ? f1 : (opn_q ? ir_q[3:0] : ir_q[7:4]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH_A;
            pc_q        <= PC_START;
            ir_q        <= '0;
            ptr_q       <= '0;
            dst_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            opn_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            ptr_q       <= ptr_d;
            dst_q       <= dst_d;
            a_q         <= a_d;
            b_q         <= b_d;
            opn_q       <= opn_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        alu_res = a_q;
        case (op)
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUB:  alu_res = a_q - b_q;
            OP_MUL:  alu_res = a_q * b_q;
            OP_DIV:  alu_res = (b_q == '0) ? {DATA_WIDTH{1'b1}} : a_q / b_q;
            default: alu_res = a_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        ptr_d       = ptr_q;
        dst_d       = dst_q;
        a_d         = a_q;
        b_d         = b_q;
        opn_d       = opn_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        src_done    = 1'b0;
        case (state_q)
            S_FETCH_A: state_d = S_FETCH_D;
            S_FETCH_D: begin
                ir_d    = bus.mem_in[15:0];
                pc_d    = pc_q + 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                opn_d = 1'b0;
                dst_d = ADDR_WIDTH'(f1[2:0]);
                case (op)
                    OP_MOV, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_OUT: state_d = S_SRC_A;
                    OP_IN:   state_d = f1[3] ? S_DST_A : S_IN_WAIT;
                    OP_STOP: state_d = S_HALT;
                    default: state_d = S_FETCH_A;
                endcase
            end
            S_SRC_A: state_d = S_SRC_D;
            S_SRC_D: begin
                if (cur_fld[3]) begin
                    ptr_d   = bus.mem_in[ADDR_WIDTH-1:0];
                    state_d = S_SRC_IA;
                end else begin
                    src_done = 1'b1;
                end
            end
            S_SRC_IA: state_d = S_SRC_ID;
            S_SRC_ID: src_done = 1'b1;
            S_DST_A:  state_d = S_DST_D;
            S_DST_D: begin
                dst_d   = bus.mem_in[ADDR_WIDTH-1:0];
                state_d = (op == OP_IN) ? S_IN_WAIT : S_WRITE;
            end
            S_WRITE:   state_d = S_FETCH_A;
            S_IN_WAIT: if (bus.in_valid) state_d = S_FETCH_A;
            S_OUT_WAIT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_FETCH_A;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH_A;
        endcase

        if (src_done) begin
            if (opn_q) b_d = bus.mem_in;
            else       a_d = bus.mem_in;
            if (op == OP_OUT) begin
                out_data_d  = bus.mem_in;
                out_valid_d = 1'b1;
                state_d     = S_OUT_WAIT;
            end else if (is_alu && !opn_q) begin
                opn_d   = 1'b1;
                state_d = S_SRC_A;
            end else begin
                state_d = f1[3] ? S_DST_A : S_WRITE;
            end
        end
    end

    always_comb begin
        bus.mem_addr  = pc_q;
        bus.mem_we    = 1'b0;
        bus.mem_data  = alu_res;
        bus.in_ready  = 1'b0;
        bus.halted    = (state_q == S_HALT);
        bus.out_data  = out_data_q;
        bus.out_valid = out_valid_q;
        bus.pc        = pc_q;
        bus.sp        = SP_START;
        case (state_q)
            S_SRC_A:  bus.mem_addr = ADDR_WIDTH'(cur_fld[2:0]);
            S_SRC_IA: bus.mem_addr = ptr_q;
            S_DST_A:  bus.mem_addr = ADDR_WIDTH'(f1[2:0]);
            S_WRITE: begin
                bus.mem_addr = dst_q;
                bus.mem_we   = 1'b1;
            end
            S_IN_WAIT: begin
                bus.in_ready = 1'b1;
                bus.mem_addr = dst_q;
                bus.mem_data = bus.in_data;
                bus.mem_we   = bus.in_valid;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_cpu_hs.sv
// Directed scenarios plus random programs compared against an instruction-level model.
module tb_cpu_hs;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic load  = 1'b0;
    always #5 clk = ~clk;

    cpu_hs_if bus ();
    cpu_hs dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [15:0] mem [64];
    logic [15:0] img [64];
    logic [15:0] rm  [64];
    logic [15:0] in_q [64];
    logic [15:0] exp_out [$];
    logic [15:0] got_out [$];
    int total = 0;
    int bad   = 0;

    always @(posedge clk) begin
        if (load) mem <= img;
        else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_data;
        bus.mem_in <= mem[bus.mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 64; i++) img[i] = 16'h0000;
    endtask

    // Loads img while reset is held; returns on the negedge where reset is released.
    task automatic start_prog();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_until_halt(output int cyc);
        cyc = 0;
        while (!bus.halted && cyc < 500) begin
            cyc++;
            @(negedge clk);
        end
        check_eq("halt_reached", 32'(bus.halted), 32'd1);
    endtask

    function automatic logic [5:0] ea(input logic [3:0] f);
        logic [15:0] p;
        p = rm[f[2:0]];
        return f[3] ? p[5:0] : {3'b000, f[2:0]};
    endfunction

    // Instruction-level interpreter: one loop iteration per instruction.
    task automatic model_run(output int ncyc, output logic [5:0] mpc, output bit ok);
        logic [15:0] ir, a, b, r;
        int ni, steps;
        bit done;
        ncyc = 0; mpc = 6'd8; ok = 1'b0; ni = 0; steps = 0; done = 1'b0;
        exp_out.delete();
        while (!done && steps < 200) begin
            steps++;
            ir = rm[mpc];
            mpc = mpc + 6'd1;
            case (ir[15:12])
                4'h0: begin
                    rm[ea(ir[11:8])] = rm[ea(ir[7:4])];
                    ncyc += 6 + 2 * (int'(ir[11]) + int'(ir[7]));
                end
                4'h1, 4'h2, 4'h3, 4'h4: begin
                    a = rm[ea(ir[7:4])];
                    b = rm[ea(ir[3:0])];
                    case (ir[15:12])
                        4'h1:    r = a + b;
                        4'h2:    r = a - b;
                        4'h3:    r = a * b;
                        default: r = (b == 16'd0) ? 16'hFFFF : a / b;
                    endcase
                    rm[ea(ir[11:8])] = r;
                    ncyc += 8 + 2 * (int'(ir[11]) + int'(ir[7]) + int'(ir[3]));
                end
                4'h7: begin
                    if (ni >= 64) done = 1'b1;
                    else begin
                        rm[ea(ir[11:8])] = in_q[ni];
                        ni++;
                        ncyc += 4 + 2 * int'(ir[11]);
                    end
                end
                4'h8: begin
                    exp_out.push_back(rm[ea(ir[11:8])]);
                    ncyc += 6 + 2 * int'(ir[11]);
                end
                4'hF: begin
                    ncyc += 3;
                    ok = 1'b1;
                    done = 1'b1;
                end
                default: ncyc += 3;
            endcase
        end
    endtask

    task automatic gen_prog();
        logic [3:0] op;
        for (int i = 0; i < 64; i++) img[i] = 16'($urandom);
        for (int i = 0; i < 8; i++) img[i] = {10'($urandom), 1'b1, 5'($urandom)};
        for (int i = 8; i < 24; i++) begin
            case ($urandom_range(0, 9))
                0: op = 4'h0; 1: op = 4'h1; 2: op = 4'h2; 3: op = 4'h3; 4: op = 4'h4;
                5: op = 4'h7; 6: op = 4'h8; 7: op = 4'h5;
                default: op = 4'($urandom_range(1, 4));
            endcase
            img[i] = {op, 12'($urandom)};
        end
        img[24] = 16'hF000;
        for (int i = 0; i < 64; i++) in_q[i] = 16'($urandom);
    endtask

    initial begin
        int cyc;
        // Reset in the middle of an ADD, then run the arithmetic program.
        clear_img();
        img[1] = 16'd7; img[2] = 16'd5;
        img[8] = 16'h1112; img[9] = 16'h2312; img[10] = 16'h3412; img[11] = 16'h4512; img[12] = 16'hF000;
        start_prog();
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_pc", 32'(bus.pc), 32'd8);
        check_eq("rst_sp", 32'(bus.sp), 32'd63);
        check_eq("rst_we", 32'(bus.mem_we), 32'd0);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_out_data", 32'(bus.out_data), 32'd0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("rst_halted", 32'(bus.halted), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("restart_addr", 32'(bus.mem_addr), 32'd8);
        run_until_halt(cyc);
        check_eq("alu_cycles", 32'(cyc), 32'd35);
        check_eq("add", 32'(mem[1]), 32'd12);
        check_eq("sub", 32'(mem[3]), 32'd7);
        check_eq("mul", 32'(mem[4]), 32'd60);
        check_eq("div", 32'(mem[5]), 32'd2);
        check_eq("halt_pc", 32'(bus.pc), 32'd13);
        check_eq("halt_we", 32'(bus.mem_we), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("halt_stays", 32'(bus.pc), 32'd13);

        // Wraparound add and divide by zero.
        clear_img();
        img[1] = 16'hFFFF; img[2] = 16'd2; img[6] = 16'd0;
        img[8] = 16'h1312; img[9] = 16'h4416; img[10] = 16'hF000;
        start_prog();
        run_until_halt(cyc);
        check_eq("add_wrap", 32'(mem[3]), 32'h0001);
        check_eq("div_zero", 32'(mem[4]), 32'hFFFF);
        check_eq("wrap_cycles", 32'(cyc), 32'd19);

        // Indirect destination MOV.
        clear_img();
        img[0] = 16'h0020; img[6] = 16'h1234; img[8] = 16'h0860; img[9] = 16'hF000;
        start_prog();
        run_until_halt(cyc);
        check_eq("mov_ind", 32'(mem[32]), 32'h1234);
        check_eq("mov_cycles", 32'(cyc), 32'd11);

        // IN with a delayed producer.
        clear_img();
        img[8] = 16'h7100; img[9] = 16'hF000;
        start_prog();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("in_wait_rdy%0d", i), 32'(bus.in_ready), 32'd1);
            check_eq($sformatf("in_wait_we%0d", i), 32'(bus.mem_we), 32'd0);
            @(negedge clk);
        end
        bus.in_valid = 1'b1; bus.in_data = 16'hABCD;
        #1;
        check_eq("in_we", 32'(bus.mem_we), 32'd1);
        check_eq("in_addr", 32'(bus.mem_addr), 32'd1);
        check_eq("in_data", 32'(bus.mem_data), 32'hABCD);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_eq("in_ready_drop", 32'(bus.in_ready), 32'd0);
        check_eq("in_mem", 32'(mem[1]), 32'hABCD);
        run_until_halt(cyc);

        // OUT with a delayed consumer.
        clear_img();
        img[2] = 16'h0055; img[8] = 16'h8200; img[9] = 16'hF000;
        start_prog();
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("out_vld%0d", i), 32'(bus.out_valid), 32'd1);
            check_eq($sformatf("out_dat%0d", i), 32'(bus.out_data), 32'h55);
            check_eq($sformatf("out_pc%0d", i), 32'(bus.pc), 32'd9);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_eq("out_vld_drop", 32'(bus.out_valid), 32'd0);
        check_eq("out_dat_hold", 32'(bus.out_data), 32'h55);
        check_eq("out_next_fetch", 32'(bus.mem_addr), 32'd9);
        run_until_halt(cyc);

        // Random programs with random handshake timing.
        for (int t = 0; t < 6; t++) begin
            bit ok;
            int mcyc, guard, ii, act;
            logic [5:0] mpc;
            ok = 1'b0;
            while (!ok) begin
                gen_prog();
                for (int i = 0; i < 64; i++) rm[i] = img[i];
                model_run(mcyc, mpc, ok);
            end
            got_out.delete();
            start_prog();
            act = 0; guard = 0; ii = 0;
            while (!bus.halted && guard < 4000) begin
                bus.in_valid  = (ii < 64) && ($urandom_range(0, 2) != 0);
                bus.in_data   = (ii < 64) ? in_q[ii] : 16'h0000;
                bus.out_ready = ($urandom_range(0, 2) != 0);
                #1;
                if (!((bus.in_ready && !bus.in_valid) || (bus.out_valid && !bus.out_ready))) act++;
                if (bus.in_ready && bus.in_valid) ii++;
                if (bus.out_valid && bus.out_ready) got_out.push_back(bus.out_data);
                guard++;
                @(negedge clk);
            end
            bus.in_valid = 1'b0; bus.out_ready = 1'b0;
            check_eq($sformatf("rnd%0d_halt", t), 32'(bus.halted), 32'd1);
            check_eq($sformatf("rnd%0d_pc", t), 32'(bus.pc), 32'(mpc));
            check_eq($sformatf("rnd%0d_cycles", t), 32'(act), 32'(mcyc));
            check_eq($sformatf("rnd%0d_nout", t), 32'(got_out.size()), 32'(exp_out.size()));
            for (int i = 0; i < exp_out.size(); i++)
                if (i < got_out.size())
                    check_eq($sformatf("rnd%0d_out%0d", t, i), 32'(got_out[i]), 32'(exp_out[i]));
            for (int i = 0; i < 64; i++)
                check_eq($sformatf("rnd%0d_mem%0d", t, i), 32'(mem[i]), 32'(rm[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
